// File: rtl/pcm_sample_feeder.sv
// Stereo sample FIFO feeding the I2S DAC; pops one L/R pair per lrck frame with priming,
// underrun and flush handling. Optional volume stage enabled by PCM_SAMPLE_FEEDER_VOLUME_EN.
module pcm_sample_feeder #(
   parameter int unsigned DEPTH_LOG2  = 4,
   parameter int unsigned PRIME_LEVEL = 8,
   parameter logic [15:0] SILENCE     = 16'h8000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [15:0]           wr_left_i,
   input  logic [15:0]           wr_right_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic                  lrck_i,
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
   input  logic [7:0]            volume_i,
`endif
   output logic [15:0]           left_o,
   output logic [15:0]           right_o,
   output logic [DEPTH_LOG2:0]   level_o,
   output logic                  underrun_o,
   output logic [15:0]           underrun_cnt_o
);

   localparam int unsigned        Depth    = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DepthLvl = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2:0] PrimeLvl = (DEPTH_LOG2 + 1)'(PRIME_LEVEL);
   localparam logic [DEPTH_LOG2:0] LvlOne   = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

   typedef enum logic {StPrime, StRun} state_e;

   state_e                state_q, state_d;
   logic                  lrck_meta_q, lrck_sync_q, lrck_prev_q;
   logic [2:0]            arm_q;
   logic [31:0]           mem_q [Depth];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [15:0]           left_q, left_d, right_q, right_d;
   logic                  underrun_q, underrun_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  tick, push, pop, wr_ready, load_en;
   logic [31:0]           load_data;

`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
   logic        load_scale;
   logic        stg_vld_q, stg_vld_d, stg_scale_q, stg_scale_d;
   logic [31:0] stg_data_q, stg_data_d;

   function automatic logic [15:0] scale_sample(input logic [15:0] s, input logic [7:0] v);
      logic signed [24:0] a, b, prod, shr;
      logic [15:0]        res;
      a    = 25'(signed'(s ^ 16'h8000));
      b    = 25'({1'b0, v});
      prod = a * b;
      shr  = prod >>> 7;
      if (shr > 25'sd32767)       res = 16'h7FFF;
      else if (shr < -25'sd32768) res = 16'h8000;
      else                        res = shr[15:0];
      return res ^ 16'h8000;
   endfunction
`endif

   // arm_q keeps tick low until the previous-value flop holds a real sampled level, so an
   // lrck that is already high when reset releases does not look like a rising edge.
   assign tick = arm_q[2] & lrck_sync_q & ~lrck_prev_q;

   always_comb begin
      wr_ready   = (level_q != DepthLvl);
      push       = wr_valid_i & wr_ready & ~flush_i;
      pop        = 1'b0;
      state_d    = state_q;
      underrun_d = 1'b0;
      cnt_d      = cnt_q;
      load_en    = 1'b0;
      load_data  = {SILENCE, SILENCE};
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
      load_scale = 1'b0;
`endif
      if (flush_i) begin
         state_d = StPrime;
      end else begin
         unique case (state_q)
            StPrime: begin
               if (tick) load_en = 1'b1;
               if (level_q >= PrimeLvl) state_d = StRun;
            end
            StRun: begin
               if (tick) begin
                  if (level_q != '0) begin
                     pop       = 1'b1;
                     load_en   = 1'b1;
                     load_data = mem_q[rd_ptr_q];
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
                     load_scale = 1'b1;
`endif
                  end else begin
                     underrun_d = 1'b1;
                     if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                     state_d = StPrime;
                  end
               end
            end
            default: state_d = StPrime;
         endcase
      end

      wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop)      level_d = level_q + LvlOne;
      else if (pop && !push) level_d = level_q - LvlOne;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end

      left_d  = left_q;
      right_d = right_q;
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
      stg_vld_d   = load_en;
      stg_scale_d = load_scale;
      stg_data_d  = load_data;
      if (flush_i) begin
         left_d  = SILENCE;
         right_d = SILENCE;
      end else if (stg_vld_q) begin
         left_d  = stg_scale_q ? scale_sample(stg_data_q[31:16], volume_i) : stg_data_q[31:16];
         right_d = stg_scale_q ? scale_sample(stg_data_q[15:0], volume_i) : stg_data_q[15:0];
      end
`else
      if (flush_i) begin
         left_d  = SILENCE;
         right_d = SILENCE;
      end else if (load_en) begin
         left_d  = load_data[31:16];
         right_d = load_data[15:0];
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lrck_meta_q <= 1'b0;
         lrck_sync_q <= 1'b0;
         lrck_prev_q <= 1'b0;
         arm_q       <= '0;
         state_q     <= StPrime;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         left_q      <= SILENCE;
         right_q     <= SILENCE;
         underrun_q  <= 1'b0;
         cnt_q       <= '0;
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
         stg_vld_q   <= 1'b0;
         stg_scale_q <= 1'b0;
         stg_data_q  <= '0;
`endif
      end else begin
         lrck_meta_q <= lrck_i;
         lrck_sync_q <= lrck_meta_q;
         lrck_prev_q <= lrck_sync_q;
         arm_q       <= {arm_q[1:0], 1'b1};
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         left_q      <= left_d;
         right_q     <= right_d;
         underrun_q  <= underrun_d;
         cnt_q       <= cnt_d;
`ifdef PCM_SAMPLE_FEEDER_VOLUME_EN
         stg_vld_q   <= stg_vld_d;
         stg_scale_q <= stg_scale_d;
         stg_data_q  <= stg_data_d;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {wr_left_i, wr_right_i};
   end

   assign wr_ready_o     = wr_ready;
   assign left_o         = left_q;
   assign right_o        = right_q;
   assign level_o        = level_q;
   assign underrun_o     = underrun_q;
   assign underrun_cnt_o = cnt_q;

endmodule

// File: doc/pcm_sample_feeder.md
Name: pcm_sample_feeder

Overview:
- Stereo sample buffer directly upstream of the PCM5102 I2S DAC stage.
- Accepts 16-bit unsigned (0x8000-biased) L/R sample pairs from the audio mixer through a valid/ready handshake.
- Paces playout from the DAC's lrck output, popping one pair per I2S frame.
- Holds left/right stable for the whole frame and handles priming, underrun and flush so the DAC never sees a mid-frame change or garbage.

Parameters:
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 stereo pairs (default 16).
- PRIME_LEVEL, 8, fill level that must be reached before playout starts or resumes; legal range 1..2**DEPTH_LOG2.
- SILENCE, 16'h8000, output value while not playing (unsigned mid-scale).

Ports:
- clk  in  1  system clock, 28 MHz; same clock as the DAC stage.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO and playout state; one-cycle pulse or level.
- wr_left  in  16  left sample to push.
- wr_right  in  16  right sample to push.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO can accept; a push occurs when wr_valid && wr_ready.
- lrck_in  in  1  lrck from DAC stage; treated as asynchronous.
- left  out  16  sample to the DAC left input.
- right  out  16  sample to the DAC right input.
- level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
- underrun  out  1  one-cycle pulse on each underrun event.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Reset values:
  - left = right = SILENCE, wr_ready = 1, level = 0, underrun = 0, underrun_cnt = 0.
  - Sync flops = 0, state = PRIME, FIFO pointers = 0.
- lrck synchronisation and tick:
  - lrck_in passes through a 2-flop synchroniser; a third flop holds the previous value.
  - tick is high for exactly one clk on a synchronised 0->1 transition (mid-frame, during the right half).
  - Updating on the rising edge gives at least 16 bck periods of setup before the DAC latches on the lrck falling edge.
- Write side:
  - wr_ready = (level != 2**DEPTH_LOG2), driven from registered level.
  - A push writes the {wr_left, wr_right} pair at wr_ptr, and wr_ptr wraps modulo depth.
- FSM, PRIME state:
  - left/right are forced to SILENCE on tick and nothing is popped.
  - Transition to RUN when level >= PRIME_LEVEL.
- FSM, RUN state:
  - On tick with level > 0: pop the pair at rd_ptr into left/right, and rd_ptr wraps.
  - On tick with level == 0: this is an underrun. left/right hold their last value, underrun pulses, underrun_cnt increments (saturating at 16'hFFFF), and the state goes to PRIME.
- Latency: tick in cycle N gives new left/right visible from cycle N+1. Outputs change only on cycles following a tick, a flush or a reset.
- Simultaneous push and pop in the same cycle: level is unchanged and both pointers advance.
- Push into an empty FIFO on a tick cycle: the pop sees level == 0, so an underrun occurs; the pushed pair is retained and level becomes 1.
- Full FIFO: wr_ready = 0 and wr_valid is ignored with no overwrite; a pop in the same cycle raises wr_ready on the next cycle.
- Flush:
  - Pointers and level are cleared, state = PRIME, left/right = SILENCE on the next cycle.
  - A push in the same cycle as flush is discarded.
  - underrun_cnt is not cleared.
  - Flush takes priority over tick.
- Reset asserted mid-frame: all outputs return asynchronously to their reset values. After release, the first tick is not generated until a fresh synchronised 0->1 edge occurs, so an lrck already high at release gives no tick.

Optional Feature:
- Macro: PCM_SAMPLE_FEEDER_VOLUME_EN.
- When defined:
  - Adds port volume in 8, where 0x80 is unity and 0xFF is about 2x.
  - A popped sample s is output as SILENCE + sat16(((s - 16'h8000) signed * volume) >>> 7).
  - Arithmetic is a 24-bit signed product; the result saturates to -32768..32767 before re-biasing.
  - One extra register stage is added, so tick in cycle N gives output visible at N+2.
  - SILENCE and held values are not scaled.
- When undefined: there is no volume port, samples pass unmodified, and latency is N+1.

Test Plan:
- Reset, then toggle lrck_in with a 32-bck period while pushing nothing -> left/right stay 16'h8000, state PRIME, underrun never pulses.
- Push 8 pairs (L=16'h1000+i, R=16'h2000+i), then apply lrck edges -> first tick outputs 16'h1000/16'h2000 one clk after tick, then one pair per tick in order, level decrementing 8,7,...
- Push 16 pairs with wr_valid held high -> wr_ready drops with level=16, a 17th push is ignored, and the next tick pops pair 0 and restores wr_ready.
- Drain to empty in RUN -> next tick pulses underrun for 1 clk, underrun_cnt=1, left/right hold the last pair, and state returns to PRIME until level >= 8.
- Flush with 5 pairs buffered and a push in the same cycle -> level=0 and left/right=16'h8000 next cycle, underrun_cnt unchanged.
- With PCM_SAMPLE_FEEDER_VOLUME_EN and volume=0x40, pop s=16'hC000 -> output 16'hA000 at tick+2. With volume=0xFF and s=16'hFFFF -> output saturates to 16'hFFFF.
